// File: rtl/alu_op_issuer_pkg.sv
// Shared opcodes, FSM state encoding and widths for the ALU operation issuer.
package alu_issuer_pkg;

    localparam int unsigned OPC_W     = 4;
    localparam int unsigned OPCOUNT_W = 16;
    localparam int unsigned LAT_W     = 4;

    localparam logic [OPC_W-1:0] ADD     = 4'd0;
    localparam logic [OPC_W-1:0] SUB     = 4'd1;
    localparam logic [OPC_W-1:0] AND     = 4'd2;
    localparam logic [OPC_W-1:0] OR      = 4'd3;
    localparam logic [OPC_W-1:0] ROL     = 4'd4;
    localparam logic [OPC_W-1:0] PASSB   = 4'd5;
    localparam logic [OPC_W-1:0] ROR     = 4'd6;
    localparam logic [OPC_W-1:0] MUL     = 4'd7;
    localparam logic [OPC_W-1:0] OPC_MAX = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
        return opc <= OPC_MAX;
    endfunction

endpackage

// File: rtl/alu_op_issuer_if.sv
// Command, ALU-side and response signals of the issuer; slave = issuer view, master = fabric/ALU view.
interface alu_op_issuer_if #(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned SHIFT_W = 5,
    parameter int unsigned TAG_W   = 4
);
    logic               cmdValid;
    logic               cmdReady;
    logic [3:0]         cmdOpcode;
    logic [WIDTH-1:0]   cmdInput1;
    logic [WIDTH-1:0]   cmdInput2;
    logic [SHIFT_W-1:0] cmdShift;
    logic [TAG_W-1:0]   cmdTag;

    logic [3:0]         aluOpcode;
    logic [WIDTH-1:0]   aluInput1;
    logic [WIDTH-1:0]   aluInput2;
    logic [SHIFT_W-1:0] aluShiftValue;
    logic [WIDTH-1:0]   aluResult;
    logic               aluCarryFlag;

    logic               rspValid;
    logic               rspReady;
    logic [WIDTH-1:0]   rspResult;
    logic               rspCarry;
    logic [TAG_W-1:0]   rspTag;
    logic               rspError;

    modport slave (
        input  cmdValid, cmdOpcode, cmdInput1, cmdInput2, cmdShift, cmdTag,
        input  aluResult, aluCarryFlag, rspReady,
        output cmdReady, aluOpcode, aluInput1, aluInput2, aluShiftValue,
        output rspValid, rspResult, rspCarry, rspTag, rspError
    );

    modport master (
        output cmdValid, cmdOpcode, cmdInput1, cmdInput2, cmdShift, cmdTag,
        output aluResult, aluCarryFlag, rspReady,
        input  cmdReady, aluOpcode, aluInput1, aluInput2, aluShiftValue,
        input  rspValid, rspResult, rspCarry, rspTag, rspError
    );
endinterface

// File: rtl/alu_op_issuer_timer.sv
// Loadable down-counter timing the ALU latency; done_c is high while the count is zero.
module alu_latency_timer #(
    parameter int unsigned LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] value,
    output logic             done_c
);
    logic [LAT_W-1:0] cnt_q;

    // Counts down to zero and parks there until the next load
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - LAT_W'(1);
        end
    end

    assign done_c = (cnt_q == '0);
endmodule

// File: rtl/alu_op_issuer.sv
// Issues one tagged operation at a time to a generated ALU and returns result/carry.
// Optional macro ALU_OPCODE_CHECK_EN: opcodes above OPC_MAX bypass the ALU and answer with rspError=1.
module alu_op_issuer
    import alu_issuer_pkg::*;
#(
    parameter int unsigned WIDTH       = 128,
    parameter int unsigned SHIFT_W     = 5,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned ALU_LATENCY = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_op_issuer_if.slave       bus,
    output logic [OPCOUNT_W-1:0] opCount
);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LATENCY);

    state_e               state;
    logic [TAG_W-1:0]     tag_q;
    logic [OPCOUNT_W-1:0] op_cnt_q;
    logic                 accept_c;
    logic                 rsp_hs_c;
    logic                 lat_done_c;

    assign accept_c = (state == IDLE) && bus.cmdValid && bus.cmdReady;
    assign rsp_hs_c = bus.rspValid && bus.rspReady;
    assign opCount  = op_cnt_q;

    alu_latency_timer #(.LAT_W(LAT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (accept_c),
        .value  (LAT_LOAD),
        .done_c (lat_done_c)
    );

`ifndef ALU_OPCODE_CHECK_EN
    assign bus.rspError = 1'b0;
`endif

    // Issue FSM; alu* only move on acceptance, rsp* only on capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            bus.cmdReady      <= 1'b1;
            bus.aluOpcode     <= 4'd0;
            bus.aluInput1     <= WIDTH'(0);
            bus.aluInput2     <= WIDTH'(0);
            bus.aluShiftValue <= SHIFT_W'(0);
            bus.rspValid      <= 1'b0;
            bus.rspResult     <= WIDTH'(0);
            bus.rspCarry      <= 1'b0;
            bus.rspTag        <= TAG_W'(0);
`ifdef ALU_OPCODE_CHECK_EN
            bus.rspError      <= 1'b0;
`endif
            tag_q             <= TAG_W'(0);
            op_cnt_q          <= OPCOUNT_W'(0);
        end else begin
            op_cnt_q <= op_cnt_q + OPCOUNT_W'(rsp_hs_c);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        bus.cmdReady <= 1'b0;
                        tag_q        <= bus.cmdTag;
`ifdef ALU_OPCODE_CHECK_EN
                        if (!opc_legal(bus.cmdOpcode)) begin
                            bus.rspValid  <= 1'b1;
                            bus.rspResult <= WIDTH'(0);
                            bus.rspCarry  <= 1'b0;
                            bus.rspTag    <= bus.cmdTag;
                            bus.rspError  <= 1'b1;
                            state         <= RESP;
                        end else begin
`else
                        begin
`endif
                            bus.aluOpcode     <= bus.cmdOpcode;
                            bus.aluInput1     <= bus.cmdInput1;
                            bus.aluInput2     <= bus.cmdInput2;
                            bus.aluShiftValue <= bus.cmdShift;
                            state             <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (lat_done_c) begin
                        bus.rspValid  <= 1'b1;
                        bus.rspResult <= bus.aluResult;
                        bus.rspCarry  <= bus.aluCarryFlag;
                        bus.rspTag    <= tag_q;
`ifdef ALU_OPCODE_CHECK_EN
                        bus.rspError  <= 1'b0;
`endif
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_hs_c) begin
                        bus.rspValid <= 1'b0;
                        bus.cmdReady <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    bus.rspValid <= 1'b0;
                    bus.cmdReady <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer: latency 0 and latency 3 instances driving a behavioural ALU stub.
module tb_alu_op_issuer;
    import alu_issuer_pkg::*;

    localparam int unsigned WIDTH   = 128;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned TAG_W   = 4;
    localparam logic [127:0] ONES   = {128{1'b1}};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cnt0;
    logic [15:0] cnt3;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    alu_op_issuer_if #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W)) bus0 ();
    alu_op_issuer_if #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W)) bus3 ();

    alu_op_issuer #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W), .ALU_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .opCount(cnt0)
    );
    alu_op_issuer #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W), .ALU_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .opCount(cnt3)
    );

    // Behavioural ALU: {carry, result}
    function automatic logic [128:0] alu_model(input logic [3:0] opc, input logic [127:0] a,
                                               input logic [127:0] b, input logic [4:0] sh);
        case (opc)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return {1'b0, a | b};
            4'd4:    return {1'b0, (a << sh) | (a >> (128 - int'(sh)))};
            4'd5:    return {1'b0, b};
            4'd6:    return {1'b0, (a >> sh) | (a << (128 - int'(sh)))};
            4'd7:    return {1'b0, a * b};
            default: return 129'd0;
        endcase
    endfunction

    assign {bus0.aluCarryFlag, bus0.aluResult} =
        alu_model(bus0.aluOpcode, bus0.aluInput1, bus0.aluInput2, bus0.aluShiftValue);
    assign {bus3.aluCarryFlag, bus3.aluResult} =
        alu_model(bus3.aluOpcode, bus3.aluInput1, bus3.aluInput2, bus3.aluShiftValue);

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd0(input logic [3:0] opc, input logic [127:0] a, input logic [127:0] b,
                        input logic [4:0] sh, input logic [3:0] tag);
        bus0.cmdValid  = 1'b1;
        bus0.cmdOpcode = opc;
        bus0.cmdInput1 = a;
        bus0.cmdInput2 = b;
        bus0.cmdShift  = sh;
        bus0.cmdTag    = tag;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus0.cmdValid = 1'b0; bus0.cmdOpcode = '0; bus0.cmdInput1 = '0; bus0.cmdInput2 = '0;
        bus0.cmdShift = '0;   bus0.cmdTag = '0;    bus0.rspReady = 1'b0;
        bus3.cmdValid = 1'b0; bus3.cmdOpcode = '0; bus3.cmdInput1 = '0; bus3.cmdInput2 = '0;
        bus3.cmdShift = '0;   bus3.cmdTag = '0;    bus3.rspReady = 1'b0;
        tick(); tick();
        rst = 1'b0;

        check("rst_cmdReady", 128'(bus0.cmdReady), 128'd1);
        check("rst_rspValid", 128'(bus0.rspValid), 128'd0);
        check("rst_aluOpcode", 128'(bus0.aluOpcode), 128'd0);
        check("rst_aluInput1", bus0.aluInput1, 128'd0);
        check("rst_rspResult", bus0.rspResult, 128'd0);
        check("rst_opCount", 128'(cnt0), 128'd0);

        // ADD 5+7, latency 0
        cmd0(ADD, 128'd5, 128'd7, 5'd0, 4'd3);
        bus0.rspReady = 1'b1;
        tick();
        bus0.cmdValid = 1'b0;
        check("add_n1_cmdReady", 128'(bus0.cmdReady), 128'd0);
        check("add_n1_rspValid", 128'(bus0.rspValid), 128'd0);
        check("add_n1_aluInput1", bus0.aluInput1, 128'd5);
        tick();
        check("add_n2_rspValid", 128'(bus0.rspValid), 128'd1);
        check("add_result", bus0.rspResult, 128'd12);
        check("add_tag", 128'(bus0.rspTag), 128'd3);
        check("add_carry", 128'(bus0.rspCarry), 128'd0);
        check("add_error", 128'(bus0.rspError), 128'd0);
        tick();
        check("add_n3_rspValid", 128'(bus0.rspValid), 128'd0);
        check("add_n3_cmdReady", 128'(bus0.cmdReady), 128'd1);
        check("add_opCount", 128'(cnt0), 128'd1);

        // SUB 0-1 on the latency-3 instance
        bus3.cmdValid = 1'b1; bus3.cmdOpcode = SUB; bus3.cmdInput1 = 128'd0;
        bus3.cmdInput2 = 128'd1; bus3.cmdTag = 4'd6; bus3.rspReady = 1'b1;
        tick();
        bus3.cmdValid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("sub_n%0d_cmdReady", k), 128'(bus3.cmdReady), 128'd0);
            check($sformatf("sub_n%0d_rspValid", k), 128'(bus3.rspValid), 128'(k == 5));
            if (k < 5) tick();
        end
        check("sub_result", bus3.rspResult, ONES);
        check("sub_carry", 128'(bus3.rspCarry), 128'd1);
        check("sub_tag", 128'(bus3.rspTag), 128'd6);
        tick();
        check("sub_n6_cmdReady", 128'(bus3.cmdReady), 128'd1);
        check("sub_n6_rspValid", 128'(bus3.rspValid), 128'd0);
        check("sub_opCount", 128'(cnt3), 128'd1);

        // Backpressure: response held for 10 cycles, a second command waits
        cmd0(AND, 128'hF0F0, 128'hFF00, 5'd0, 4'd5);
        bus0.rspReady = 1'b0;
        tick();
        cmd0(PASSB, 128'd0, 128'hABCD, 5'd0, 4'd9);
        tick();
        for (int k = 0; k < 10; k++) begin
            check("bp_rspValid", 128'(bus0.rspValid), 128'd1);
            check("bp_rspResult", bus0.rspResult, 128'hF000);
            check("bp_rspTag", 128'(bus0.rspTag), 128'd5);
            check("bp_cmdReady", 128'(bus0.cmdReady), 128'd0);
            check("bp_aluOpcode", 128'(bus0.aluOpcode), 128'(AND));
            tick();
        end
        bus0.rspReady = 1'b1;
        tick();
        check("bp_rel_rspValid", 128'(bus0.rspValid), 128'd0);
        check("bp_rel_cmdReady", 128'(bus0.cmdReady), 128'd1);
        check("bp_opCount", 128'(cnt0), 128'd2);
        tick();
        bus0.cmdValid = 1'b0;
        check("bp2_cmdReady", 128'(bus0.cmdReady), 128'd0);
        check("bp2_aluOpcode", 128'(bus0.aluOpcode), 128'(PASSB));
        check("bp2_aluInput2", bus0.aluInput2, 128'hABCD);
        tick();
        check("bp2_rspValid", 128'(bus0.rspValid), 128'd1);
        check("bp2_rspResult", bus0.rspResult, 128'hABCD);
        check("bp2_rspTag", 128'(bus0.rspTag), 128'd9);
        tick();
        check("bp2_opCount", 128'(cnt0), 128'd3);

        // Rotate left 1 by 4; alu* must hold afterwards
        cmd0(ROL, 128'd1, 128'd0, 5'd4, 4'd2);
        tick();
        bus0.cmdValid = 1'b0;
        bus0.cmdShift = 5'd0;
        tick();
        check("rol_result", bus0.rspResult, 128'd16);
        check("rol_tag", 128'(bus0.rspTag), 128'd2);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rol_hold_shift", 128'(bus0.aluShiftValue), 128'd4);
            check("rol_hold_opcode", 128'(bus0.aluOpcode), 128'(ROL));
        end
        check("rol_opCount", 128'(cnt0), 128'd4);

        // Reset while the latency-3 instance is in EXEC
        bus3.cmdValid = 1'b1; bus3.cmdOpcode = ADD; bus3.cmdInput1 = 128'd1;
        bus3.cmdInput2 = 128'd2; bus3.cmdTag = 4'd1;
        tick();
        bus3.cmdValid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("abort_rspValid", 128'(bus3.rspValid), 128'd0);
            check("abort_cmdReady", 128'(bus3.cmdReady), 128'd1);
            check("abort_opCount", 128'(cnt3), 128'd0);
            tick();
        end
        check("abort_opCount0", 128'(cnt0), 128'd0);

        // Preload the counter at its top value, then one completion wraps it
        force dut0.op_cnt_q = 16'hFFFF;
        tick(); tick();
        release dut0.op_cnt_q;
        tick();
        check("wrap_pre", 128'(cnt0), 128'hFFFF);
        cmd0(ADD, ONES, 128'd1, 5'd0, 4'd15);
        tick();
        bus0.cmdValid = 1'b0;
        tick();
        check("wrap_add_result", bus0.rspResult, 128'd0);
        check("wrap_add_carry", 128'(bus0.rspCarry), 128'd1);
        check("wrap_add_tag", 128'(bus0.rspTag), 128'd15);
        tick();
        check("wrap_opCount", 128'(cnt0), 128'd0);

`ifdef ALU_OPCODE_CHECK_EN
        cmd0(4'd9, 128'd3, 128'd4, 5'd1, 4'd7);
        tick();
        bus0.cmdValid = 1'b0;
        check("chk_rspValid", 128'(bus0.rspValid), 128'd1);
        check("chk_rspError", 128'(bus0.rspError), 128'd1);
        check("chk_rspResult", bus0.rspResult, 128'd0);
        check("chk_rspTag", 128'(bus0.rspTag), 128'd7);
        check("chk_aluOpcode", 128'(bus0.aluOpcode), 128'(ADD));
        check("chk_aluInput1", bus0.aluInput1, ONES);
        tick();
        check("chk_opCount", 128'(cnt0), 128'd1);
        check("chk_cmdReady", 128'(bus0.cmdReady), 128'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
